pc_next_unit: RTL

PC_NEXT_UNIT -- requirements
Module: pc_next_unit

---
 rtl/otter_pkg.sv | 23 ++
 rtl/pc_src_mux.sv | 30 +++
 rtl/pc_next_unit.sv | 97 +++++++++
 3 files changed

// File: rtl/otter_pkg.sv
// Shared encodings for the PC-next datapath: PC source select codes and trap FSM states.
package otter_pkg;

    typedef enum logic [2:0] {
        SRC_SEQ    = 3'b000,
        SRC_JALR   = 3'b001,
        SRC_BRANCH = 3'b010,
        SRC_JAL    = 3'b011,
        SRC_MTVEC  = 3'b100,
        SRC_MEPC   = 3'b101
    } pc_src_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } trap_state_t;

    // Only control-transfer targets computed by the core can be misaligned.
    function automatic logic is_checked_src(input logic [2:0] src);
        return (src == SRC_JALR) || (src == SRC_BRANCH) || (src == SRC_JAL);
    endfunction

endpackage

// File: rtl/pc_src_mux.sv
// Combinational next-PC target selection; reserved source codes fall back to PC+4.
module pc_src_mux
    import otter_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      sel,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] jalr,
    input  logic [XLEN-1:0] branch,
    input  logic [XLEN-1:0] jal,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] target
);

    always_comb begin
        target = pc_plus4;
        case (sel)
            SRC_SEQ:    target = pc_plus4;
            SRC_JALR:   target = {jalr[XLEN-1:1], 1'b0};
            SRC_BRANCH: target = branch;
            SRC_JAL:    target = jal;
            SRC_MTVEC:  target = mtvec;
            SRC_MEPC:   target = mepc;
            default:    target = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_next_unit.sv
// PC register with target selection, interrupt capture FSM and misaligned-target trapping.
module pc_next_unit
    import otter_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            PC_WRITE,
    input  logic [2:0]      PC_SOURCE,
    input  logic [XLEN-1:0] JALR,
    input  logic [XLEN-1:0] BRANCH,
    input  logic [XLEN-1:0] JAL,
    input  logic [XLEN-1:0] MTVEC,
    input  logic [XLEN-1:0] MEPC,
    input  logic            TRAP_REQ,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PC_PLUS4,
    output logic            TRAP_ACK,
    output logic [XLEN-1:0] TRAP_EPC,
    output logic            MISALIGN,
    output logic            FSM_STATE
);

    // TRAP_REQ may be a level or a one-cycle pulse; it is remembered across stalls
    // and acknowledged exactly once by a TRAP_ACK pulse on the advancing cycle.
    trap_state_t     state, state_next;
    logic [XLEN-1:0] pc_q, epc_q, target;
    logic            ack_q, mis_q;
    logic            trap_take, mis_take;

    assign PC        = pc_q;
    assign PC_PLUS4  = pc_q + XLEN'(4);
    assign TRAP_ACK  = ack_q;
    assign TRAP_EPC  = epc_q;
    assign MISALIGN  = mis_q;
    assign FSM_STATE = (state == ST_PENDING);

    pc_src_mux #(.XLEN(XLEN)) u_mux (
        .sel      (PC_SOURCE),
        .pc_plus4 (PC_PLUS4),
        .jalr     (JALR),
        .branch   (BRANCH),
        .jal      (JAL),
        .mtvec    (MTVEC),
        .mepc     (MEPC),
        .target   (target)
    );

    always_comb begin
        state_next = state;
        trap_take  = 1'b0;
        mis_take   = 1'b0;
        if (PC_WRITE) begin
            trap_take  = (state == ST_PENDING) || TRAP_REQ;
            mis_take   = is_checked_src(PC_SOURCE) && target[1];
            state_next = ST_IDLE;
        end else if (TRAP_REQ) begin
            state_next = ST_PENDING;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An interrupt coinciding with a bad target returns to the faulting PC,
    // so the bad jump is re-executed after the handler and traps then.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q  <= RESET_VEC;
            epc_q <= '0;
            ack_q <= 1'b0;
            mis_q <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            mis_q <= 1'b0;
            if (trap_take) begin
                pc_q  <= MTVEC;
                epc_q <= mis_take ? pc_q : target;
                ack_q <= 1'b1;
            end else if (mis_take) begin
                pc_q  <= MTVEC;
                epc_q <= pc_q;
                mis_q <= 1'b1;
            end else if (PC_WRITE) begin
                pc_q <= target;
            end
        end
    end

endmodule
